// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter (8N1 default): pushes land in a FIFO, FSM serialises LSB first; push-to-start-bit 2 cycles.
// No backpressure: a push while full is dropped and sets sticky ovf. Define UART_TX_PARITY_EN for an even parity bit.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Full is the registered flag, so a push while full is lost even if a pop frees a slot.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok)
      level_nxt = level + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      level_nxt = level - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end
endmodule

module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rstn_i,
  input  logic                          uart_wr_i,
  input  logic [DATA_BITS-1:0]          uart_dat_i,
  output logic                          uart_full_o,
  output logic                          uart_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
  output logic                          uart_busy_o,
  output logic                          uart_ovf_o,
  input  logic                          uart_ovf_clr_i,
  output logic                          uart_tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_chk
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state, state_nxt;
  logic [CW-1:0]         baud_cnt, baud_cnt_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0]  shreg, shreg_nxt;
  logic [DATA_BITS-1:0]  head;
  logic                  tx_nxt;
  logic                  pop;
  logic                  tick;
`ifdef UART_TX_PARITY_EN
  logic                  par, par_nxt;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk_i),
    .rst_n    (sys_rstn_i),
    .push     (uart_wr_i),
    .push_dat (uart_dat_i),
    .pop      (pop),
    .pop_dat  (head),
    .full     (uart_full_o),
    .empty    (uart_empty_o),
    .level    (uart_level_o)
  );

  assign tick        = (baud_cnt == CW'(DIV - 1));
  assign uart_busy_o = (state != IDLE) || !uart_empty_o;

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    tx_nxt       = 1'b1;
    pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt      = par;
`endif
    case (state)
      IDLE: begin
        if (!uart_empty_o) begin
          pop          = 1'b1;
          shreg_nxt    = head;
`ifdef UART_TX_PARITY_EN
          par_nxt      = ^head;
`endif
          baud_cnt_nxt = '0;
          state_nxt    = START;
        end
      end
      START: begin
        tx_nxt       = 1'b0;
        baud_cnt_nxt = baud_cnt + CW'(1);
        if (tick) begin
          baud_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        tx_nxt       = shreg[0];
        baud_cnt_nxt = baud_cnt + CW'(1);
        if (tick) begin
          baud_cnt_nxt = '0;
          shreg_nxt    = shreg >> 1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt       = par;
        baud_cnt_nxt = baud_cnt + CW'(1);
        if (tick) begin
          baud_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = STOP;
        end
      end
`endif
      STOP: begin
        baud_cnt_nxt = baud_cnt + CW'(1);
        if (tick) begin
          baud_cnt_nxt = '0;
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_cnt_nxt = '0;
            // Chain straight into the next start bit so queued bytes leave no idle gap.
            if (!uart_empty_o) begin
              pop       = 1'b1;
              shreg_nxt = head;
`ifdef UART_TX_PARITY_EN
              par_nxt   = ^head;
`endif
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      uart_tx  <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      par      <= par_nxt;
`endif
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i)
      uart_ovf_o <= 1'b0;
    else if (uart_wr_i && uart_full_o)
      uart_ovf_o <= 1'b1;
    else if (uart_ovf_clr_i)
      uart_ovf_o <= 1'b0;
  end
endmodule
